// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
//
// Source-domain end of a 4-phase (return-to-zero) req/ack clock-domain
// crossing. A word is captured from a local valid/ready interface and held
// stable on ov_xdata while a registered request is raised toward the
// destination domain. The returning acknowledge is asynchronous to i_clk, so
// it passes through a flop chain before the control logic looks at it. The
// next word is accepted only once the acknowledge has returned low.
//
// Parameters:
//   p_WIDTH        width of the transferred data word
//   p_SYNC_STAGES  flops in the i_ack synchronizer (values below 2 use 2)
//   p_TIMEOUT      cycles to wait for the synchronized ack after req rises;
//                  0 disables the timeout
//
// Ports:
//   i_clk      source-domain clock
//   i_rst_n    asynchronous active-low reset (release synchronous to i_clk)
//   i_valid    local request to send iv_data
//   iv_data    word to send, sampled only on accept
//   o_ready    block can accept a word this cycle
//   ov_xdata   crossing data bus, changes only on accept
//   o_req      crossing request, registered and glitch-free
//   i_ack      crossing acknowledge from the destination domain (async)
//   o_done     one-cycle pulse: ack was seen high and then low
//   o_timeout  one-cycle pulse: ack not seen within p_TIMEOUT cycles
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
    parameter int p_WIDTH       = 8,
    parameter int p_SYNC_STAGES = 2,
    parameter int p_TIMEOUT     = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [p_WIDTH-1:0] iv_data,
    output logic               o_ready,
    output logic [p_WIDTH-1:0] ov_xdata,
    output logic               o_req,
    input  logic               i_ack,
    output logic               o_done,
    output logic               o_timeout
);

    // A single flop cannot resolve metastability, so the chain never gets
    // shorter than two stages even if a smaller value is passed in.
    localparam int LP_STAGES = (p_SYNC_STAGES < 2) ? 2 : p_SYNC_STAGES;

    // The wait counter only has to reach p_TIMEOUT-1; it is cleared whenever
    // the request phase ends, so it can never wrap while it matters.
    localparam int LP_CNT_W = (p_TIMEOUT > 1) ? $clog2(p_TIMEOUT) : 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST =
        LP_CNT_W'((p_TIMEOUT > 0) ? (p_TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ_HIGH = 2'd1,
        ST_REQ_LOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LP_STAGES-1:0]  r_ackSync;
    logic [LP_CNT_W-1:0]   r_waitCnt;
    logic                  r_timedOut;

    logic                  w_ackS;
    logic                  w_accept;
    logic                  w_timeoutHit;

    // Acknowledge synchronizer. i_ack enters at bit 0 and the control logic
    // only ever looks at the last stage; the raw input is never used
    // combinationally anywhere else.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ackSync <= '0;
        end else begin
            r_ackSync <= {r_ackSync[LP_STAGES-2:0], i_ack};
        end
    end

    assign w_ackS = r_ackSync[LP_STAGES-1];

    // A stale ack left over from an aborted transfer (timeout or reset)
    // holds off the next accept until the destination has let go of it.
    assign o_ready  = (r_state == ST_IDLE) && !w_ackS;
    assign w_accept = i_valid && o_ready;

    assign w_timeoutHit = (p_TIMEOUT != 0) && (r_waitCnt == LP_CNT_LAST);

    // Handshake sequencer. All crossing outputs come straight from flops so
    // the destination never sees a glitch on o_req or ov_xdata. o_done and
    // o_timeout default low every cycle to make them single-cycle pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            o_req      <= 1'b0;
            ov_xdata   <= '0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            r_waitCnt  <= '0;
            r_timedOut <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        ov_xdata   <= iv_data;
                        o_req      <= 1'b1;
                        r_waitCnt  <= '0;
                        r_timedOut <= 1'b0;
                        r_state    <= ST_REQ_HIGH;
                    end
                end

                // Ack is checked before the timeout so that an ack arriving
                // on the very last allowed cycle still counts as success.
                ST_REQ_HIGH: begin
                    if (w_ackS) begin
                        o_req     <= 1'b0;
                        r_waitCnt <= '0;
                        r_state   <= ST_REQ_LOW;
                    end else if (w_timeoutHit) begin
                        o_req      <= 1'b0;
                        o_timeout  <= 1'b1;
                        r_timedOut <= 1'b1;
                        r_waitCnt  <= '0;
                        r_state    <= ST_REQ_LOW;
                    end else if (p_TIMEOUT != 0) begin
                        r_waitCnt <= r_waitCnt + LP_CNT_W'(1);
                    end
                end

                // Return-to-zero phase has no timeout: the responder is
                // expected to follow req down eventually. A transfer that
                // timed out finishes silently instead of reporting done.
                ST_REQ_LOW: begin
                    if (!w_ackS) begin
                        o_done  <= !r_timedOut;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    o_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_tx
//
// Bench for cdc_handshake_tx with p_WIDTH=8, p_SYNC_STAGES=2, p_TIMEOUT=10.
// A transfer-level reference model predicts every output each cycle, and
// directed scenarios pin latencies and pulse counts with hand-derived values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

    localparam int W = 8;
    localparam int S = 2;
    localparam int T = 10;

    logic         i_clk   = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] iv_data = '0;
    logic         i_ack;
    logic         o_ready;
    logic [W-1:0] ov_xdata;
    logic         o_req;
    logic         o_done;
    logic         o_timeout;

    logic respAuto  = 1'b0;
    logic manualAck = 1'b0;
    logic autoAck   = 1'b0;
    int   respCnt   = 0;

    int   tests   = 0;
    int   fails   = 0;
    logic checkEn = 1'b0;

    assign i_ack = respAuto ? autoAck : manualAck;

    always #5 i_clk = ~i_clk;

    cdc_handshake_tx #(
        .p_WIDTH       (W),
        .p_SYNC_STAGES (S),
        .p_TIMEOUT     (T)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .iv_data   (iv_data),
        .o_ready   (o_ready),
        .ov_xdata  (ov_xdata),
        .o_req     (o_req),
        .i_ack     (i_ack),
        .o_done    (o_done),
        .o_timeout (o_timeout)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d);
        i_valid = v;
        iv_data = d;
    endtask

    // Destination-side responder: follows o_req with ack after three
    // consecutive falling edges of disagreement.
    always @(negedge i_clk) begin
        if (!respAuto || !i_rst_n) begin
            autoAck <= 1'b0;
            respCnt <= 0;
        end else if (o_req != autoAck) begin
            if (respCnt == 2) begin
                autoAck <= o_req;
                respCnt <= 0;
            end else begin
                respCnt <= respCnt + 1;
            end
        end else begin
            respCnt <= 0;
        end
    end

    // Transfer-level reference model. ackHist holds the last S samples of
    // i_ack; a transfer is "busy" from accept until ack has been seen low
    // after req dropped, and reqHigh says whether we are still asking.
    logic [S-1:0] ackHist;
    logic         mBusy, mReqHigh, mTimedOut, mDone, mTimeout;
    logic [W-1:0] mData;
    int           mHighCycles;
    logic         mAckS;

    assign mAckS = ackHist[S-1];

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ackHist     <= '0;
            mBusy       <= 1'b0;
            mReqHigh    <= 1'b0;
            mTimedOut   <= 1'b0;
            mDone       <= 1'b0;
            mTimeout    <= 1'b0;
            mData       <= '0;
            mHighCycles <= 0;
        end else begin
            ackHist  <= {ackHist[S-2:0], i_ack};
            mDone    <= 1'b0;
            mTimeout <= 1'b0;
            if (!mBusy) begin
                if (i_valid && !mAckS) begin
                    mData       <= iv_data;
                    mBusy       <= 1'b1;
                    mReqHigh    <= 1'b1;
                    mTimedOut   <= 1'b0;
                    mHighCycles <= 1;
                end
            end else if (mReqHigh) begin
                if (mAckS) begin
                    mReqHigh <= 1'b0;
                end else if (mHighCycles == T) begin
                    mReqHigh  <= 1'b0;
                    mTimeout  <= 1'b1;
                    mTimedOut <= 1'b1;
                end else begin
                    mHighCycles <= mHighCycles + 1;
                end
            end else if (!mAckS) begin
                mBusy <= 1'b0;
                mDone <= !mTimedOut;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge i_clk) begin
        if (i_rst_n && checkEn) begin
            checkOutput("cycle",
                {20'd0, o_req, o_ready, o_done, o_timeout, ov_xdata},
                {20'd0, mReqHigh, (!mBusy && !mAckS), mDone, mTimeout, mData});
        end
    end

    // Results of the most recent runTransfer call.
    int   rDoneLat, rReqHigh, rDoneCnt, rToCnt, rToLat, rReadyLat;
    logic rReadyMid;

    // Offers one word for a single cycle (called just after a falling edge
    // with o_ready high), then observes a fixed number of falling edges,
    // optionally toggling the manual ack at given edge numbers.
    task automatic runTransfer(input logic [W-1:0] word, input int ackOn, input int ackOff, input int cycles);
        rDoneLat  = 0;
        rReqHigh  = 0;
        rDoneCnt  = 0;
        rToCnt    = 0;
        rToLat    = 0;
        rReadyLat = 0;
        rReadyMid = 1'b1;
        applyStimulus(1'b1, word);
        for (int k = 1; k <= cycles; k++) begin
            @(negedge i_clk);
            if (k == 1) applyStimulus(1'b0, '0);
            if (k == ackOn) manualAck = 1'b1;
            if (k == ackOff) manualAck = 1'b0;
            if (o_req) rReqHigh++;
            if (o_timeout) begin
                rToCnt++;
                if (rToLat == 0) rToLat = k;
            end
            if (o_done) begin
                rDoneCnt++;
                if (rDoneLat == 0) rDoneLat = k;
            end
            if (o_ready && rReadyLat == 0) rReadyLat = k;
            if (k == 16) rReadyMid = o_ready;
        end
    endtask

    logic [W-1:0] words [3];
    logic [W-1:0] doneData [3];
    int           idx, b2bDone, b2bLast;
    logic         readyPrev;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        // Reset values while reset is held.
        repeat (2) @(negedge i_clk);
        checkOutput("reset_req",     {31'd0, o_req},     32'd0);
        checkOutput("reset_xdata",   {24'd0, ov_xdata},  32'd0);
        checkOutput("reset_ready",   {31'd0, o_ready},   32'd1);
        checkOutput("reset_done",    {31'd0, o_done},    32'd0);
        checkOutput("reset_timeout", {31'd0, o_timeout}, 32'd0);
        i_rst_n = 1'b1;
        checkEn = 1'b1;

        // Single transfer with a 3-cycle responder.
        respAuto = 1'b1;
        runTransfer(8'hA5, 0, 0, 14);
        checkOutput("single_done_lat",  rDoneLat,  32'd11);
        checkOutput("single_done_cnt",  rDoneCnt,  32'd1);
        checkOutput("single_req_high",  rReqHigh,  32'd5);
        checkOutput("single_to_cnt",    rToCnt,    32'd0);
        checkOutput("single_ready_lat", rReadyLat, 32'd11);
        checkOutput("single_xdata",     {24'd0, ov_xdata}, 32'hA5);

        // Back-to-back with i_valid held; the word advances after each accept.
        idx = 0;
        b2bDone = 0;
        b2bLast = 0;
        readyPrev = o_ready;
        applyStimulus(1'b1, words[0]);
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clk);
            if (readyPrev && i_valid) begin
                idx++;
                if (idx < 3) applyStimulus(1'b1, words[idx]);
                else         applyStimulus(1'b0, '0);
            end
            if (o_done) begin
                if (b2bDone < 3) doneData[b2bDone] = ov_xdata;
                b2bDone++;
                b2bLast = k;
            end
            readyPrev = o_ready;
        end
        checkOutput("b2b_accepts",  idx,     32'd3);
        checkOutput("b2b_done_cnt", b2bDone, 32'd3);
        checkOutput("b2b_last",     b2bLast, 32'd33);
        checkOutput("b2b_data0", {24'd0, doneData[0]}, 32'h01);
        checkOutput("b2b_data1", {24'd0, doneData[1]}, 32'h02);
        checkOutput("b2b_data2", {24'd0, doneData[2]}, 32'h03);

        // Timeout with ack tied low.
        respAuto  = 1'b0;
        manualAck = 1'b0;
        runTransfer(8'h3C, 0, 0, 14);
        checkOutput("to_req_high",  rReqHigh,  32'd10);
        checkOutput("to_cnt",       rToCnt,    32'd1);
        checkOutput("to_lat",       rToLat,    32'd11);
        checkOutput("to_done_cnt",  rDoneCnt,  32'd0);
        checkOutput("to_ready_lat", rReadyLat, 32'd12);

        // Late ack after timeout blocks o_ready while it is synchronized high.
        runTransfer(8'hE7, 12, 20, 24);
        checkOutput("late_to_cnt",    rToCnt,    32'd1);
        checkOutput("late_done_cnt",  rDoneCnt,  32'd0);
        checkOutput("late_ready_mid", {31'd0, rReadyMid}, 32'd0);
        checkOutput("late_ready_end", {31'd0, o_ready},   32'd1);

        respAuto = 1'b1;
        runTransfer(8'h5A, 0, 0, 14);
        checkOutput("after_late_done_lat", rDoneLat, 32'd11);
        checkOutput("after_late_done_cnt", rDoneCnt, 32'd1);
        checkOutput("after_late_xdata", {24'd0, ov_xdata}, 32'h5A);

        // Synchronized ack arrives on the last allowed cycle: ack wins.
        respAuto = 1'b0;
        runTransfer(8'h77, 8, 14, 20);
        checkOutput("edge_to_cnt",   rToCnt,   32'd0);
        checkOutput("edge_done_cnt", rDoneCnt, 32'd1);
        checkOutput("edge_done_lat", rDoneLat, 32'd17);
        checkOutput("edge_req_high", rReqHigh, 32'd10);

        // One cycle later the timeout fires first.
        runTransfer(8'h78, 9, 14, 20);
        checkOutput("late1_to_cnt",    rToCnt,    32'd1);
        checkOutput("late1_to_lat",    rToLat,    32'd11);
        checkOutput("late1_done_cnt",  rDoneCnt,  32'd0);
        checkOutput("late1_ready_lat", rReadyLat, 32'd17);

        // Reset in the middle of a transfer with ack held high.
        applyStimulus(1'b1, 8'hC3);
        @(negedge i_clk);
        applyStimulus(1'b0, '0);
        @(negedge i_clk);
        manualAck = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_pre_req",   {31'd0, o_req},    32'd1);
        checkOutput("rst_pre_xdata", {24'd0, ov_xdata}, 32'hC3);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_async_req",   {31'd0, o_req},    32'd0);
        checkOutput("rst_async_xdata", {24'd0, ov_xdata}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_stale_r2", {31'd0, o_ready}, 32'd0);
        @(negedge i_clk);
        checkOutput("rst_stale_r3", {31'd0, o_ready}, 32'd0);
        manualAck = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_stale_r4", {31'd0, o_ready}, 32'd0);
        @(negedge i_clk);
        checkOutput("rst_stale_r5", {31'd0, o_ready}, 32'd1);

        respAuto = 1'b1;
        runTransfer(8'h81, 0, 0, 14);
        checkOutput("post_rst_done_lat", rDoneLat, 32'd11);
        checkOutput("post_rst_xdata", {24'd0, ov_xdata}, 32'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
